connect4_draw_engine: RTL and testbench
=======================================

# connect4_draw_engine

Pixel sequencer between the Connect Four game controller and the VGA adapter. It accepts one draw request at a time: either a dropped piece at a board cell, or a pointer move above the board. It walks the 4x4 pixel footprint and emits one `x`/`y`/`colour`/`plot` pixel per clock. A pointer move first erases the old pointer, then draws the new one, so the controller never tracks the pointer's screen position.

## Interface
Parameters:
- `X_ORIGIN`, default 16: screen x of the left edge of column 0.
- `Y_ORIGIN`, default 20: screen y of the top edge of row 5 (top board row). Must be ≥ `CELL_PITCH`.
- `CELL_PITCH`, default 8: pixel spacing between adjacent cells; the pointer row sits one pitch above row 5.

Ports:
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `req` in 1: draw request; sampled only when `ready`=1.
- `req_kind` in 1: 0 = piece, 1 = pointer move.
- `req_col` in 3: board column, 0..6.
- `req_row` in 3: board row, 0 = bottom, 0..5; ignored for pointer.
- `req_player` in 1: colour select; 0 = red (3'b100), 1 = yellow (3'b110).
- `ready` out 1: engine idle, request accepted this edge if `req`=1.
- `x` out 8: pixel x.
- `y` out 7: pixel y.
- `colour` out 3: pixel RGB.
- `plot` out 1: VGA write enable; `x`/`y`/`colour` are valid while high.
- `done` out 1: one-cycle pulse at end of request.

## Operation
- States: IDLE, ERASE, DRAW, FINISH.
- Registers:
  - `ptr_col` (3b, reset 3)
  - 4b pixel counter `cnt`
  - latched `kind`/`col`/`row`/`player`
- IDLE: `ready`=1, `plot`=0. On `req`=1, latch the request fields, clear `cnt`, and branch:
  - invalid request → FINISH. Invalid means `col`>6, or `kind`=0 with `row`>5.
  - valid pointer → ERASE.
  - valid piece → DRAW.
- ERASE: paints the 16 pixels at column `ptr_col`, pointer row, colour 3'b000. After `cnt`=15 → DRAW, with `cnt` cleared.
- DRAW: paints the 16 pixels at the latched cell in the player colour. After `cnt`=15 → FINISH. For a pointer request, `ptr_col` ← latched `col` on the transition to FINISH.
- FINISH: `done`=1, `ready`=0, `plot`=0 → IDLE.
- Pixel address: `dx`=`cnt[1:0]`, `dy`=`cnt[3:2]`.
  - x = `X_ORIGIN` + col·`CELL_PITCH` + `dx`.
  - Piece y = `Y_ORIGIN` + (5−row)·`CELL_PITCH` + `dy`.
  - Pointer y = `Y_ORIGIN` − `CELL_PITCH` + `dy`.
- Arithmetic is computed at 9 bits and truncated to the port widths. Parameters must keep results in range; defaults give a maximum x of 67 and a maximum y of 63.
- A pointer move to the same column still performs both erase and draw (32 pixels).
- `req` while `ready`=0 is ignored, not queued.
- Invalid requests produce no plots and leave `ptr_col` unchanged.

## Timing
- Reset values: state IDLE, `ready`=1, `plot`=0, `done`=0, `x`=0, `y`=0, `colour`=0, `ptr_col`=3, `cnt`=0.
- Outputs are registered. Edge E0 accepts the request; `ready` falls in the cycle after E0.
- Piece: `plot`=1 for cycles 1..16 with `cnt` 0..15 in order; `done`=1 in cycle 17; `ready`=1 from cycle 18.
- Pointer: erase pixels in cycles 1..16, draw pixels in 17..32 with no gap; `done` in cycle 33; `ready` from cycle 34.
- Invalid: `done` in cycle 1; `ready` from cycle 2.
- `resetn` low mid-operation: outputs and state go to reset values immediately (asynchronously). Partially drawn pixels are not repaired, and the screen is not guaranteed to match `ptr_col`=3.
- `done` and `req` in the same cycle: `ready`=0, so the request is dropped. The controller must wait for `ready`.

## Test plan
- Reset, then piece `col`=0, `row`=0, `player`=0 → 16 plots, colour 3'b100; x 16..19, y 60..63; raster order (x,y) = (16,60), (17,60) … (19,63); `done` in cycle 17.
- Pointer to `col`=6, `player`=1 → 16 black plots at x 40..43, y 12..15; then 16 plots at x 64..67, y 12..15, colour 3'b110; `done` in cycle 33. A following pointer move to `col`=2 erases at x 64..67.
- Pointer move to the current column 3 → erase then draw both at x 40..43, 32 plots total.
- Invalid piece `col`=7, and invalid piece `row`=6 → zero plots, `done` in cycle 1, `ptr_col` unchanged.
- `req` pulses held during a busy draw → ignored; exactly 16 plots occur and one `done`.
- `resetn` asserted at pixel 8 of a pointer erase → `plot`=0 immediately; `ready`=1 after release; the next pointer move erases at column 3 (x 40..43).

Source files
------------

// File: rtl/connect4_draw_engine.sv
// Connect Four draw engine: turns one piece/pointer draw request into a
// stream of 4x4 pixel writes for the VGA adapter.  A pointer move first
// blacks out the old pointer, then paints the new one, and remembers the
// pointer column so the game controller never has to.
module connect4_draw_engine #(
  parameter int X_ORIGIN   = 16,
  parameter int Y_ORIGIN   = 20,
  parameter int CELL_PITCH = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req,
  input  logic       req_kind,
  input  logic [2:0] req_col,
  input  logic [2:0] req_row,
  input  logic       req_player,
  output logic       ready,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, FINISH} state_t;

  localparam logic [8:0] XO    = 9'(X_ORIGIN);
  localparam logic [8:0] YO    = 9'(Y_ORIGIN);
  localparam logic [8:0] PITCH = 9'(CELL_PITCH);

  state_t     state;
  logic [2:0] ptr_col;
  logic [3:0] cnt;
  logic       kind;
  logic [2:0] col;
  logic [2:0] row;
  logic       player;

  function automatic logic [7:0] pix_x(input logic [2:0] c, input logic [3:0] n);
    return 8'(XO + {6'd0, c} * PITCH + {7'd0, n[1:0]});
  endfunction

  function automatic logic [6:0] pix_y_piece(input logic [2:0] r, input logic [3:0] n);
    return 7'(YO + (9'd5 - {6'd0, r}) * PITCH + {7'd0, n[3:2]});
  endfunction

  function automatic logic [6:0] pix_y_ptr(input logic [3:0] n);
    return 7'(YO - PITCH + {7'd0, n[3:2]});
  endfunction

  function automatic logic [2:0] player_colour(input logic p);
    return p ? 3'b110 : 3'b100;
  endfunction

  // Sequencer: each edge picks the next state and registers the pixel that
  // belongs to it, so the first pixel appears the cycle after acceptance.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      ptr_col <= 3'd3;
      cnt     <= 4'd0;
      kind    <= 1'b0;
      col     <= 3'd0;
      row     <= 3'd0;
      player  <= 1'b0;
      ready   <= 1'b1;
      plot    <= 1'b0;
      done    <= 1'b0;
      x       <= 8'd0;
      y       <= 7'd0;
      colour  <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b1;
          plot  <= 1'b0;
          done  <= 1'b0;
          if (req) begin
            kind   <= req_kind;
            col    <= req_col;
            row    <= req_row;
            player <= req_player;
            cnt    <= 4'd0;
            ready  <= 1'b0;
            if (req_col > 3'd6 || (!req_kind && req_row > 3'd5)) begin
              state <= FINISH;
              done  <= 1'b1;
            end else if (req_kind) begin
              state  <= ERASE;
              plot   <= 1'b1;
              x      <= pix_x(ptr_col, 4'd0);
              y      <= pix_y_ptr(4'd0);
              colour <= 3'b000;
            end else begin
              state  <= DRAW;
              plot   <= 1'b1;
              x      <= pix_x(req_col, 4'd0);
              y      <= pix_y_piece(req_row, 4'd0);
              colour <= player_colour(req_player);
            end
          end
        end
        ERASE: begin
          if (cnt == 4'd15) begin
            state  <= DRAW;
            cnt    <= 4'd0;
            x      <= pix_x(col, 4'd0);
            y      <= pix_y_ptr(4'd0);
            colour <= player_colour(player);
          end else begin
            cnt <= cnt + 4'd1;
            x   <= pix_x(ptr_col, cnt + 4'd1);
            y   <= pix_y_ptr(cnt + 4'd1);
          end
        end
        DRAW: begin
          if (cnt == 4'd15) begin
            state <= FINISH;
            plot  <= 1'b0;
            done  <= 1'b1;
            if (kind) ptr_col <= col;
          end else begin
            cnt <= cnt + 4'd1;
            x   <= pix_x(col, cnt + 4'd1);
            y   <= kind ? pix_y_ptr(cnt + 4'd1) : pix_y_piece(row, cnt + 4'd1);
          end
        end
        FINISH: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
          plot  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_connect4_draw_engine.sv
// Directed bench for connect4_draw_engine: issues piece, pointer and
// invalid requests and compares the captured pixel stream against
// hand-computed screen coordinates for the default geometry.
module tb_connect4_draw_engine;

  logic       clk;
  logic       resetn;
  logic       req;
  logic       req_kind;
  logic [2:0] req_col;
  logic [2:0] req_row;
  logic       req_player;
  logic       ready;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       done;

  int vectors;
  int miscompares;

  int capX[$];
  int capY[$];
  int capC[$];
  int capCyc[$];
  int doneCycle;
  int doneCount;
  int readyCycle;
  int firstReady;

  connect4_draw_engine dut (
    .clk        (clk),
    .resetn     (resetn),
    .req        (req),
    .req_kind   (req_kind),
    .req_col    (req_col),
    .req_row    (req_row),
    .req_player (req_player),
    .ready      (ready),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .done       (done)
  );

  // 10 ns free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every vector and reports mismatches
  task automatic checkOutput(input string tag, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Issue one request and capture the resulting pixel stream cycle by cycle.
  // holdReq keeps req asserted while the engine is busy; abortAt>0 pulls
  // resetn low right after sampling that cycle.
  task automatic applyStimulus(input logic kind, input logic [2:0] c, input logic [2:0] r,
                               input logic p, input bit holdReq, input int abortAt);
    capX.delete(); capY.delete(); capC.delete(); capCyc.delete();
    doneCycle  = -1;
    doneCount  = 0;
    readyCycle = -1;
    @(negedge clk);
    firstReady = int'(ready);
    req        = 1'b1;
    req_kind   = kind;
    req_col    = c;
    req_row    = r;
    req_player = p;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      #1;
      if (plot) begin
        capX.push_back(int'(x));
        capY.push_back(int'(y));
        capC.push_back(int'(colour));
        capCyc.push_back(k);
      end
      if (done) begin
        doneCount++;
        if (doneCycle < 0) doneCycle = k;
      end
      if (k == 1) checkOutput("ready low after accept", int'(ready), 0);
      if (k == abortAt) begin
        checkOutput("plot before reset", int'(plot), 1);
        #2 resetn = 1'b0;
        #1;
        checkOutput("async reset plot", int'(plot), 0);
        checkOutput("async reset ready", int'(ready), 1);
        checkOutput("async reset x", int'(x), 0);
        checkOutput("async reset y", int'(y), 0);
        @(negedge clk);
        req    = 1'b0;
        resetn = 1'b1;
        return;
      end
      if (ready) begin
        readyCycle = k;
        break;
      end
      @(negedge clk);
      req = holdReq && !ready;
      @(posedge clk);
    end
    @(negedge clk);
    req = 1'b0;
    if (readyCycle < 0 && abortAt == 0) checkOutput("timeout waiting ready", 0, 1);
  endtask

  // Compare 16 captured pixels starting at index base against a 4x4 raster
  task automatic checkRaster(input string tag, input int base, input int x0, input int y0,
                             input int c, input int firstCyc);
    for (int i = 0; i < 16; i++) begin
      checkOutput({tag, " x"},     capX[base + i],   x0 + (i % 4));
      checkOutput({tag, " y"},     capY[base + i],   y0 + (i / 4));
      checkOutput({tag, " colour"}, capC[base + i],  c);
      checkOutput({tag, " cycle"}, capCyc[base + i], firstCyc + i);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    resetn      = 1'b0;
    req         = 1'b0;
    req_kind    = 1'b0;
    req_col     = 3'd0;
    req_row     = 3'd0;
    req_player  = 1'b0;
    #12;
    checkOutput("reset ready", int'(ready), 1);
    checkOutput("reset plot", int'(plot), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset x", int'(x), 0);
    checkOutput("reset y", int'(y), 0);
    checkOutput("reset colour", int'(colour), 0);
    @(negedge clk);
    resetn = 1'b1;

    $display("[TB] piece col0 row0 red");
    applyStimulus(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 0);
    checkOutput("piece ready before", firstReady, 1);
    checkOutput("piece plots", capX.size(), 16);
    checkRaster("piece00", 0, 16, 60, 4, 1);
    checkOutput("piece done cycle", doneCycle, 17);
    checkOutput("piece done count", doneCount, 1);
    checkOutput("piece ready cycle", readyCycle, 18);

    $display("[TB] pointer to col6 yellow");
    applyStimulus(1'b1, 3'd6, 3'd0, 1'b1, 1'b0, 0);
    checkOutput("ptr6 plots", capX.size(), 32);
    checkRaster("ptr6 erase", 0, 40, 12, 0, 1);
    checkRaster("ptr6 draw", 16, 64, 12, 6, 17);
    checkOutput("ptr6 done cycle", doneCycle, 33);
    checkOutput("ptr6 ready cycle", readyCycle, 34);

    $display("[TB] pointer to col2 red");
    applyStimulus(1'b1, 3'd2, 3'd0, 1'b0, 1'b0, 0);
    checkOutput("ptr2 plots", capX.size(), 32);
    checkRaster("ptr2 erase", 0, 64, 12, 0, 1);
    checkRaster("ptr2 draw", 16, 32, 12, 4, 17);

    $display("[TB] pointer back to col3, then same column again");
    applyStimulus(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 0);
    checkRaster("ptr3 erase", 0, 32, 12, 0, 1);
    applyStimulus(1'b1, 3'd3, 3'd0, 1'b0, 1'b0, 0);
    checkOutput("same col plots", capX.size(), 32);
    checkRaster("same erase", 0, 40, 12, 0, 1);
    checkRaster("same draw", 16, 40, 12, 4, 17);
    checkOutput("same done cycle", doneCycle, 33);

    $display("[TB] invalid requests");
    applyStimulus(1'b0, 3'd7, 3'd0, 1'b0, 1'b0, 0);
    checkOutput("bad col plots", capX.size(), 0);
    checkOutput("bad col done cycle", doneCycle, 1);
    checkOutput("bad col ready cycle", readyCycle, 2);
    applyStimulus(1'b0, 3'd2, 3'd6, 1'b1, 1'b0, 0);
    checkOutput("bad row plots", capX.size(), 0);
    checkOutput("bad row done cycle", doneCycle, 1);
    checkOutput("bad row ready cycle", readyCycle, 2);
    applyStimulus(1'b1, 3'd7, 3'd0, 1'b1, 1'b0, 0);
    checkOutput("bad ptr plots", capX.size(), 0);
    checkOutput("bad ptr done cycle", doneCycle, 1);
    applyStimulus(1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 0);
    checkRaster("ptr kept erase", 0, 40, 12, 0, 1);
    checkRaster("ptr0 draw", 16, 16, 12, 6, 17);

    $display("[TB] piece with req held while busy");
    applyStimulus(1'b0, 3'd1, 3'd5, 1'b1, 1'b1, 0);
    checkOutput("held plots", capX.size(), 16);
    checkRaster("held piece", 0, 24, 20, 6, 1);
    checkOutput("held done count", doneCount, 1);
    checkOutput("held ready cycle", readyCycle, 18);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checkOutput("no queued plot", int'(plot), 0);
      checkOutput("idle ready", int'(ready), 1);
    end

    $display("[TB] reset during pointer erase");
    applyStimulus(1'b1, 3'd5, 3'd0, 1'b1, 1'b0, 9);
    checkOutput("pre-reset erase x", capX[0], 16);
    @(posedge clk); #1;
    checkOutput("ready after release", int'(ready), 1);
    applyStimulus(1'b1, 3'd1, 3'd0, 1'b0, 1'b0, 0);
    checkOutput("post-reset plots", capX.size(), 32);
    checkRaster("post-reset erase", 0, 40, 12, 0, 1);
    checkRaster("post-reset draw", 16, 24, 12, 4, 17);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
